// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: ALU ops, operand selects and
// branch conditions. Control decodes into these same codes.
package execute_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_REG   = 2'b00,
        SRCA_PC    = 2'b01,
        SRCA_ZERO  = 2'b10,
        SRCA_ZERO2 = 2'b11
    } srca_sel_e;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_IMM2 = 2'b10,
        SRCB_FOUR = 2'b11
    } srcb_sel_e;

    // strCtrl doubles as the branch condition when PCBranch is set
    typedef enum logic [2:0] {
        BR_EQ   = 3'b000,
        BR_NE   = 3'b001,
        BR_JAL  = 3'b010,
        BR_JALR = 3'b011,
        BR_LT   = 3'b100,
        BR_GE   = 3'b101,
        BR_LTU  = 3'b110,
        BR_GEU  = 3'b111
    } br_cond_e;

endpackage

// File: rtl/execute_alu.sv
// Combinational integer ALU. Shift amount is always b[4:0]; undefined
// op codes return zero.
module alu
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result
);

    // single-cycle result select
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SRL:   result = a >> b[4:0];
            ALU_SRA:   result = $signed(a) >>> b[4:0];
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution,
// wrong-path squash after a redirect, and the EX/MEM pipeline register.
module execute
    import execute_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SQUASH_CNT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            MemtoRegE,
    input  logic            PCBranchE,
    input  logic            JALRctrlE,
    input  logic [3:0]      ALUopE,
    input  logic [1:0]      SrcASelE,
    input  logic [1:0]      SrcBSelE,
    input  logic [2:0]      strCtrlE,
    input  logic [XLEN-1:0] r1E,
    input  logic [XLEN-1:0] r2E,
    input  logic [XLEN-1:0] immE,
    input  logic [XLEN-1:0] PCE,
    input  logic [4:0]      rs1E,
    input  logic [4:0]      rs2E,
    input  logic [4:0]      rdE,
    input  logic            RegWriteW,
    input  logic [4:0]      rdW,
    input  logic [XLEN-1:0] resultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            MemtoRegM,
    output logic [2:0]      strCtrlM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [4:0]      rdM
);

    localparam int SQ_W = (SQUASH_CNT > 0) ? $clog2(SQUASH_CNT + 1) : 1;
    localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_CNT);
    localparam logic [SQ_W-1:0] SQ_ONE  = SQ_W'(1);

    logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_res, jalr_sum;
    logic [SQ_W-1:0] sq_cnt;
    logic            cond, taken, bubble;

    // forwarding: M beats W, x0 never forwards
    always_comb begin
        fwd_a = r1E;
        if (RegWriteM && rdM != 5'd0 && rdM == rs1E)      fwd_a = ALUResultM;
        else if (RegWriteW && rdW != 5'd0 && rdW == rs1E) fwd_a = resultW;
        fwd_b = r2E;
        if (RegWriteM && rdM != 5'd0 && rdM == rs2E)      fwd_b = ALUResultM;
        else if (RegWriteW && rdW != 5'd0 && rdW == rs2E) fwd_b = resultW;
    end

    // ALU operand selection
    always_comb begin
        case (SrcASelE)
            SRCA_REG: src_a = fwd_a;
            SRCA_PC:  src_a = PCE;
            default:  src_a = '0;
        endcase
        case (SrcBSelE)
            SRCB_REG:  src_b = fwd_b;
            SRCB_FOUR: src_b = XLEN'(4);
            default:   src_b = immE;
        endcase
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a      (src_a),
        .b      (src_b),
        .op     (ALUopE),
        .result (alu_res)
    );

    // branch condition on forwarded operands; JAL/JALR codes always take
    always_comb begin
        case (strCtrlE)
            BR_EQ:   cond = (fwd_a == fwd_b);
            BR_NE:   cond = (fwd_a != fwd_b);
            BR_LT:   cond = ($signed(fwd_a) <  $signed(fwd_b));
            BR_GE:   cond = ($signed(fwd_a) >= $signed(fwd_b));
            BR_LTU:  cond = (fwd_a <  fwd_b);
            BR_GEU:  cond = (fwd_a >= fwd_b);
            default: cond = 1'b1;
        endcase
    end

    assign taken     = PCBranchE && cond;
    assign bubble    = (sq_cnt != '0);
    assign PCSrcE    = taken && !bubble && rst;
    assign jalr_sum  = fwd_a + immE;
    assign PCTargetE = JALRctrlE ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                                 : (PCE + immE);

    // EX/MEM register and squash counter; squashed slots lose their enables
    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            strCtrlM   <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            rdM        <= '0;
            sq_cnt     <= '0;
        end else begin
            RegWriteM  <= RegWriteE && !bubble;
            MemWriteM  <= MemWriteE && !bubble;
            MemtoRegM  <= MemtoRegE && !bubble;
            strCtrlM   <= strCtrlE;
            ALUResultM <= alu_res;
            WriteDataM <= fwd_b;
            rdM        <= rdE;
            if (PCSrcE)      sq_cnt <= SQ_LOAD;
            else if (bubble) sq_cnt <= sq_cnt - SQ_ONE;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage: directed cases then random traffic,
// each instruction's expected EX/MEM contents queued for a monitor.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JALRctrlE;
    logic [3:0]  ALUopE;
    logic [1:0]  SrcASelE, SrcBSelE;
    logic [2:0]  strCtrlE;
    logic [31:0] r1E, r2E, immE, PCE;
    logic [4:0]  rs1E, rs2E, rdE;
    logic        RegWriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, MemtoRegM;
    logic [2:0]  strCtrlM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [4:0]  rdM;

    execute dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .PCBranchE(PCBranchE), .JALRctrlE(JALRctrlE), .ALUopE(ALUopE),
        .SrcASelE(SrcASelE), .SrcBSelE(SrcBSelE), .strCtrlE(strCtrlE),
        .r1E(r1E), .r2E(r2E), .immE(immE), .PCE(PCE),
        .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .RegWriteW(RegWriteW), .rdW(rdW), .resultW(resultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .strCtrlM(strCtrlM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .rdM(rdM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rw, mw, m2r, br, jalr;
        logic [3:0]  op;
        logic [1:0]  sa, sb;
        logic [2:0]  str;
        logic [31:0] r1, r2, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic        rww;
        logic [4:0]  rdw;
        logic [31:0] resw;
    } ins_t;

    typedef struct {
        logic        rw, mw, m2r;
        logic [2:0]  str;
        logic [31:0] alu, wd;
        logic [4:0]  rd;
    } m_t;

    m_t   q[$];
    m_t   mref = '{default: '0};
    int   kill_left = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return 32'($signed(a) >>> sh);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    // latest producer wins: the instruction now in M, then the one in W
    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] raw, input ins_t i);
        if (rs == 0) return raw;
        if (mref.rw && mref.rd == rs) return mref.alu;
        if (i.rww && i.rdw == rs) return i.resw;
        return raw;
    endfunction

    function automatic ins_t nop();
        ins_t n = '{default: '0};
        n.rst = 1'b1;
        return n;
    endfunction

    // drive one instruction at negedge, check redirect, queue expected M
    task automatic issue(input ins_t i);
        logic [31:0] a, b, sa, sb, tgt;
        logic        cond, redir;
        m_t          nx;
        @(negedge clk);
        rst = i.rst; RegWriteE = i.rw; MemWriteE = i.mw; MemtoRegE = i.m2r;
        PCBranchE = i.br; JALRctrlE = i.jalr; ALUopE = i.op;
        SrcASelE = i.sa; SrcBSelE = i.sb; strCtrlE = i.str;
        r1E = i.r1; r2E = i.r2; immE = i.imm; PCE = i.pc;
        rs1E = i.rs1; rs2E = i.rs2; rdE = i.rd;
        RegWriteW = i.rww; rdW = i.rdw; resultW = i.resw;
        #1;
        a  = operand(i.rs1, i.r1, i);
        b  = operand(i.rs2, i.r2, i);
        sa = (i.sa == 0) ? a : (i.sa == 1) ? i.pc : 32'd0;
        sb = (i.sb == 0) ? b : (i.sb == 3) ? 32'd4 : i.imm;
        case (i.str)
            3'd0: cond = (a == b);
            3'd1: cond = (a != b);
            3'd4: cond = ($signed(a) < $signed(b));
            3'd5: cond = ($signed(a) >= $signed(b));
            3'd6: cond = (a < b);
            3'd7: cond = (a >= b);
            default: cond = 1'b1;
        endcase
        redir = i.rst && i.br && cond && (kill_left == 0);
        tgt   = i.jalr ? ((a + i.imm) & 32'hFFFF_FFFE) : (i.pc + i.imm);
        chk("pcsrc", {31'd0, PCSrcE}, {31'd0, redir});
        if (redir) chk("pctarget", PCTargetE, tgt);
        nx = '{default: '0};
        if (i.rst) begin
            nx.rw  = i.rw  && (kill_left == 0);
            nx.mw  = i.mw  && (kill_left == 0);
            nx.m2r = i.m2r && (kill_left == 0);
            nx.str = i.str;
            nx.alu = ref_alu(i.op, sa, sb);
            nx.wd  = b;
            nx.rd  = i.rd;
        end
        if (!i.rst)          kill_left = 0;
        else if (redir)      kill_left = 2;
        else if (kill_left > 0) kill_left--;
        mref = nx;
        q.push_back(nx);
    endtask

    // compare DUT EX/MEM contents with the oldest queued expectation
    initial begin
        m_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("RegWriteM",  {31'd0, RegWriteM}, {31'd0, e.rw});
                chk("MemWriteM",  {31'd0, MemWriteM}, {31'd0, e.mw});
                chk("MemtoRegM",  {31'd0, MemtoRegM}, {31'd0, e.m2r});
                chk("strCtrlM",   {29'd0, strCtrlM},  {29'd0, e.str});
                chk("ALUResultM", ALUResultM, e.alu);
                chk("WriteDataM", WriteDataM, e.wd);
                chk("rdM",        {27'd0, rdM}, {27'd0, e.rd});
            end
        end
    end

    task automatic after_edge();
        @(posedge clk);
        #3;
    endtask

    initial begin
        ins_t i;
        rst = 1'b0;
        {RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JALRctrlE, RegWriteW} = '0;
        ALUopE = '0; SrcASelE = '0; SrcBSelE = '0; strCtrlE = '0;
        r1E = '0; r2E = '0; immE = '0; PCE = '0;
        rs1E = '0; rs2E = '0; rdE = '0; rdW = '0; resultW = '0;

        // reset with a taken jump presented: no redirect, M cleared
        i = nop(); i.rst = 1'b0; i.br = 1'b1; i.str = 3'b010; i.rw = 1'b1; i.rd = 5'd9;
        issue(i);
        issue(i);
        after_edge();
        chk("reset_rw", {31'd0, RegWriteM}, 32'd0);
        chk("reset_rd", {27'd0, rdM}, 32'd0);

        // back-to-back dependency through M
        i = nop(); i.rs1 = 1; i.rs2 = 2; i.rd = 5; i.rw = 1; i.r1 = 7; i.imm = 3; i.sb = 2'b01;
        issue(i);
        after_edge();
        chk("add_first", ALUResultM, 32'd10);
        i = nop(); i.rs1 = 5; i.r1 = 0; i.imm = 1; i.sb = 2'b01; i.rd = 7; i.rw = 1;
        issue(i);
        after_edge();
        chk("add_fwd_m", ALUResultM, 32'd11);

        // M beats W on the same register
        i = nop(); i.op = 4'b1010; i.sb = 2'b01; i.imm = 9; i.rd = 6; i.rw = 1;
        issue(i);
        i = nop(); i.rs2 = 6; i.r2 = 32'h55; i.rww = 1; i.rdw = 6; i.resw = 1;
        i.op = 4'b1010; i.rw = 1; i.rd = 0;
        issue(i);
        after_edge();
        chk("m_over_w", WriteDataM, 32'd9);
        // x0 never forwards from either stage
        i = nop(); i.rs2 = 0; i.r2 = 32'h77; i.rww = 1; i.rdw = 0; i.resw = 1;
        issue(i);
        after_edge();
        chk("x0_raw", WriteDataM, 32'h77);

        // BEQ taken, then two squashed slots (second one a jump that must be ignored)
        i = nop(); i.rs1 = 10; i.rs2 = 11; i.r1 = 5; i.r2 = 5; i.br = 1; i.str = 3'b000;
        i.pc = 32'h100; i.imm = 32'h20;
        issue(i);
        chk("beq_pcsrc", {31'd0, PCSrcE}, 32'd1);
        chk("beq_target", PCTargetE, 32'h120);
        i = nop(); i.rw = 1; i.rd = 3;
        issue(i);
        after_edge();
        chk("squash1", {31'd0, RegWriteM}, 32'd0);
        i.br = 1; i.str = 3'b010;
        issue(i);
        chk("squash_noredir", {31'd0, PCSrcE}, 32'd0);
        after_edge();
        chk("squash2", {31'd0, RegWriteM}, 32'd0);
        i = nop(); i.rw = 1; i.rd = 3;
        issue(i);
        after_edge();
        chk("post_squash", {31'd0, RegWriteM}, 32'd1);

        // JALR: target LSB cleared, link value from ALU
        i = nop(); i.rs1 = 12; i.r1 = 32'h203; i.imm = 4; i.jalr = 1; i.br = 1; i.str = 3'b011;
        i.sa = 2'b01; i.sb = 2'b11; i.pc = 32'h40; i.rw = 1; i.rd = 1;
        issue(i);
        chk("jalr_target", PCTargetE, 32'h206);
        after_edge();
        chk("jalr_link", ALUResultM, 32'h44);
        issue(nop());
        issue(nop());

        // shifts and compares
        i = nop(); i.rs1 = 13; i.r1 = 32'h8000_0000; i.imm = 4; i.sb = 2'b01; i.op = 4'b0111;
        issue(i);
        after_edge();
        chk("sra", ALUResultM, 32'hF800_0000);
        i.r1 = 1; i.imm = 32'hFFFF_FFFF; i.op = 4'b1001;
        issue(i);
        after_edge();
        chk("sltu", ALUResultM, 32'd1);
        i.op = 4'b1000;
        issue(i);
        after_edge();
        chk("slt", ALUResultM, 32'd0);

        // reset one cycle into a squash, then an immediate redirect
        i = nop(); i.rs1 = 14; i.rs2 = 15; i.r1 = 1; i.r2 = 2; i.br = 1; i.str = 3'b001;
        issue(i);
        chk("bne_pcsrc", {31'd0, PCSrcE}, 32'd1);
        i = nop(); i.rst = 0; i.br = 1; i.str = 3'b010; i.rw = 1; i.rd = 4; i.imm = 8; i.sb = 2'b01;
        issue(i);
        chk("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
        after_edge();
        chk("rst_alu", ALUResultM, 32'd0);
        chk("rst_rw", {31'd0, RegWriteM}, 32'd0);
        i = nop(); i.br = 1; i.str = 3'b010; i.pc = 32'h80; i.imm = 32'h10;
        issue(i);
        chk("rel_pcsrc", {31'd0, PCSrcE}, 32'd1);
        chk("rel_target", PCTargetE, 32'h90);

        // random traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            i.rst  = ($urandom_range(0, 39) != 0);
            i.rw   = 1'($urandom); i.mw = 1'($urandom); i.m2r = 1'($urandom);
            i.br   = ($urandom_range(0, 3) == 0);
            i.jalr = 1'($urandom);
            i.op   = 4'($urandom);
            i.sa   = 2'($urandom); i.sb = 2'($urandom); i.str = 3'($urandom);
            i.r1   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 + $urandom_range(0, 2) : $urandom;
            i.r2   = ($urandom_range(0, 3) == 0) ? i.r1 : $urandom;
            i.imm  = $urandom; i.pc = $urandom & 32'hFFFF_FFFC;
            i.rs1  = 5'($urandom_range(0, 7)); i.rs2 = 5'($urandom_range(0, 7));
            i.rd   = 5'($urandom_range(0, 7));
            i.rww  = 1'($urandom); i.rdw = 5'($urandom_range(0, 7)); i.resw = $urandom;
            issue(i);
        end

        after_edge();
        chk("drain", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- Execute stage of the 5-stage RV32I pipeline; consumes the ID/EX pipeline register outputs produced by decode.
- Resolves operand forwarding, computes the ALU result, resolves branches and jumps, and drives the redirect to fetch.
- Squashes wrong-path instructions that are still arriving after a taken redirect.
- Registers everything into the EX/MEM pipeline register feeding the memory stage.

Parameters:
- XLEN, 32, datapath width.
- SQUASH_CNT, 2, number of instructions entering E after a taken redirect that are turned into bubbles.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- RegWriteE, MemWriteE, MemtoRegE, PCBranchE, JALRctrlE  in  1 each  ID/EX control.
- ALUopE  in  4  ALU operation.
- SrcASelE, SrcBSelE  in  2 each  operand selects.
- strCtrlE  in  3  branch condition when PCBranchE=1; load/store width otherwise.
- r1E, r2E, immE, PCE  in  XLEN each  ID/EX data.
- rs1E, rs2E, rdE  in  5 each  register indices.
- RegWriteW  in  1  writeback enable.
- rdW  in  5  writeback destination.
- resultW  in  XLEN  writeback data.
- PCSrcE  out  1  combinational redirect request to fetch.
- PCTargetE  out  XLEN  combinational redirect target.
- RegWriteM, MemWriteM, MemtoRegM  out  1 each  EX/MEM control.
- strCtrlM  out  3  EX/MEM width control.
- ALUResultM, WriteDataM  out  XLEN each  EX/MEM data.
- rdM  out  5  EX/MEM destination.

Behaviour:
- Forwarding, per source (rs1E -> fwdA, rs2E -> fwdB):
  - If RegWriteM=1, rdM!=0 and rdM==rsE, take ALUResultM.
  - Else if RegWriteW=1, rdW!=0 and rdW==rsE, take resultW.
  - Else take r1E/r2E.
  - M has priority over W. Register 0 never forwards.
  - Load-use hazards are out of scope; the hazard unit stalls upstream.
- SrcA select: 00 fwdA, 01 PCE, 10 and 11 zero.
- SrcB select: 00 fwdB, 01 immE, 10 immE, 11 constant 4.
- ALUop encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is SrcB[4:0].
  - 1000 SLT (signed), 1001 SLTU.
  - 1010 PASS_B.
  - All others produce 0.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- Branch resolution when PCBranchE=1, comparing fwdA vs fwdB via strCtrlE:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - 010 and 011 unconditional (JAL/JALR).
- PCTargetE:
  - JALRctrlE=1: (fwdA + immE) with bit 0 cleared.
  - JALRctrlE=0: PCE + immE.
- JAL/JALR link value (PC+4) comes from the ALU (SrcA=01, SrcB=11, ADD).
- PCSrcE = taken AND squash counter == 0 AND rst == 1; otherwise 0.
- Squash counter (width clog2(SQUASH_CNT+1)):
  - Reset to 0.
  - Loaded with SQUASH_CNT on any cycle where PCSrcE=1.
  - Otherwise decrements by 1 per cycle while nonzero.
  - While nonzero, the instruction in E is a bubble: no redirect; RegWriteM, MemWriteM, MemtoRegM captured as 0.
  - A taken branch arriving while nonzero is ignored and does not reload the counter.
- EX/MEM register, captured every posedge:
  - RegWriteM, MemWriteM, MemtoRegM, strCtrlM, rdM from E (gated as above).
  - ALUResultM <= ALU result.
  - WriteDataM <= fwdB.
  - Latency: E to M outputs is exactly 1 cycle.
- Reset (rst=0 at posedge):
  - All M outputs go to 0 and the squash counter goes to 0.
  - PCSrcE is 0 combinationally while rst=0.
  - Reset mid-squash aborts the squash.
- No stall input; the block accepts one instruction per cycle.

Decomposition:
- Shared package: ALUop codes, SrcASel/SrcBSel codes, branch-condition (strCtrl) codes. These are shared with Control.
- Sub-module alu: combinational, with ports a, b, op, result. Reused by any future multi-issue work.
- Forwarding muxes, branch compare and squash counter stay in execute.

Test Plan:
- ADD with back-to-back dependency: instr1 x5=7+3; instr2 rs1=x5 (r1E stale 0), ALUop ADD, imm 1 -> ALUResultM=10 then 11 (M forward).
- W-vs-M priority: RegWriteW rdW=6 resultW=1 and RegWriteM rdM=6 ALUResultM=9, rs2E=6, SrcB=00 -> WriteDataM=9. With rdM=rdW=0 -> raw r2E is used.
- BEQ taken: fwdA=fwdB=5, strCtrlE=000, PCE=0x100, immE=0x20 -> PCSrcE=1, PCTargetE=0x120. Next 2 instructions (RegWriteE=1) produce RegWriteM=0; the third instruction writes normally.
- JALR: fwdA=0x203, immE=4, JALRctrlE=1, SrcA=01, SrcB=11, PCE=0x40 -> PCTargetE=0x206, ALUResultM=0x44.
- Shifts and compares: SRA 0x80000000 by 4 -> 0xF8000000. SLTU 1 vs 0xFFFFFFFF -> 1. SLT -> 0.
- Reset during squash: taken BNE then rst=0 one cycle later -> all M outputs 0, PCSrcE=0. After release, the next taken branch redirects immediately.
